axi_ctrl_slave: RTL and testbench

- AXI4-Lite control responder: the slave end of the host_axi bridge's s_axi_control port.
- Holds a control/status register, NUM_ARGS argument registers and one return-value register.
- Drives a start/done/ready/idle handshake to a user compute kernel.
- Replaces generated control slaves so hand-written kernels can sit behind the same host path.

---
 rtl/axi_ctrl_slave.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_axi_ctrl_slave.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ctrl_slave.sv
// axi_ctrl_slave: AXI4-Lite control responder for a hand-written compute kernel.
// Holds CTRL (start/done/idle), a latched return value and NUM_ARGS argument
// registers, and drives the ap_start/ap_ready/ap_done/ap_idle kernel handshake.
// Register map (word index = byte address >> 2):
//   word 0      CTRL  bit0 start (write-1-to-set), bit1 done (clear on read), bit2 idle
//   word 2      RET   read-only, captured when ap_done pulses
//   word 4+i    ARGi  read/write, i < NUM_ARGS
// Unmapped words read as zero and swallow writes; every response is OKAY.
module axi_ctrl_slave #(
  parameter int HOST_AXI_ADDR_BITS = 6,
  parameter int HOST_AXI_DATA_BITS = 32,
  parameter int NUM_ARGS           = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          s_axi_control_AWVALID,
  output logic                          s_axi_control_AWREADY,
  input  logic [HOST_AXI_ADDR_BITS-1:0] s_axi_control_AWADDR,
  input  logic                          s_axi_control_WVALID,
  output logic                          s_axi_control_WREADY,
  input  logic [HOST_AXI_DATA_BITS-1:0] s_axi_control_WDATA,
  input  logic [3:0]                    s_axi_control_WSTRB,
  output logic                          s_axi_control_BVALID,
  input  logic                          s_axi_control_BREADY,
  output logic [1:0]                    s_axi_control_BRESP,
  input  logic                          s_axi_control_ARVALID,
  output logic                          s_axi_control_ARREADY,
  input  logic [HOST_AXI_ADDR_BITS-1:0] s_axi_control_ARADDR,
  output logic                          s_axi_control_RVALID,
  input  logic                          s_axi_control_RREADY,
  output logic [HOST_AXI_DATA_BITS-1:0] s_axi_control_RDATA,
  output logic [1:0]                    s_axi_control_RRESP,
  output logic                          ap_start,
  input  logic                          ap_ready,
  input  logic                          ap_done,
  input  logic                          ap_idle,
  input  logic [31:0]                   ret_value,
  output logic [32*NUM_ARGS-1:0]        args
);

  // Word-granular decode: the two byte-offset bits never select anything.
  localparam int WORD_BITS     = HOST_AXI_ADDR_BITS - 2;
  localparam int ARG_BASE_WORD = 32'sd4;
  localparam logic [WORD_BITS-1:0] CTRL_WORD = WORD_BITS'(32'd0);
  localparam logic [WORD_BITS-1:0] RET_WORD  = WORD_BITS'(32'd2);

  typedef enum logic [1:0] {
    W_ADDR = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_ADDR = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Byte-lane merge: lanes with a set strobe take the new byte, others keep the old.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        result[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        result[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return result;
  endfunction

  // Write channel state
  w_state_t               w_state_r;
  w_state_t               w_state_s;
  logic [WORD_BITS-1:0]   aw_word_r;
  logic                   awready_r;
  logic                   awready_s;
  logic                   wready_r;
  logic                   wready_s;
  logic                   bvalid_r;
  logic                   bvalid_s;

  // Read channel state
  r_state_t               r_state_r;
  r_state_t               r_state_s;
  logic                   arready_r;
  logic                   arready_s;
  logic                   rvalid_r;
  logic                   rvalid_s;
  logic [31:0]            rdata_r;
  logic [31:0]            rdata_s;

  // Register file
  logic                   ap_start_r;
  logic                   done_r;
  logic [31:0]            ret_r;
  logic [NUM_ARGS-1:0][31:0] arg_r;

  // Decode / handshake helpers
  logic [WORD_BITS-1:0]   ar_word_s;
  logic                   aw_hs_s;
  logic                   wr_en_s;
  logic                   ar_hs_s;
  logic                   start_set_s;
  logic                   ctrl_rd_s;
  logic [31:0]            arg_rd_s;
  logic [31:0]            rd_mux_s;
  logic                   unused_s;

  assign ar_word_s   = s_axi_control_ARADDR[HOST_AXI_ADDR_BITS-1:2];
  assign aw_hs_s     = (w_state_r == W_ADDR) && s_axi_control_AWVALID;
  assign wr_en_s     = (w_state_r == W_DATA) && s_axi_control_WVALID;
  assign ar_hs_s     = (r_state_r == R_ADDR) && s_axi_control_ARVALID;
  assign start_set_s = wr_en_s && (aw_word_r == CTRL_WORD) &&
                       s_axi_control_WSTRB[0] && s_axi_control_WDATA[0];
  assign ctrl_rd_s   = ar_hs_s && (ar_word_s == CTRL_WORD);

  // Byte-offset address bits carry no information for a word-only register map.
  assign unused_s = ^{s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};

  // Write FSM next state plus the ready/valid levels that the next state implies.
  always_comb begin
    w_state_s = w_state_r;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    bvalid_s  = 1'b0;
    case (w_state_r)
      W_ADDR: begin
        if (s_axi_control_AWVALID) begin
          w_state_s = W_DATA;
        end else begin
          w_state_s = W_ADDR;
        end
      end
      W_DATA: begin
        if (s_axi_control_WVALID) begin
          w_state_s = W_RESP;
        end else begin
          w_state_s = W_DATA;
        end
      end
      W_RESP: begin
        if (s_axi_control_BREADY) begin
          w_state_s = W_ADDR;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: begin
        w_state_s = W_ADDR;
      end
    endcase
    case (w_state_s)
      W_ADDR:  awready_s = 1'b1;
      W_DATA:  wready_s  = 1'b1;
      W_RESP:  bvalid_s  = 1'b1;
      default: awready_s = 1'b0;
    endcase
  end

  // Write FSM state and its registered channel outputs; latch the target word on AW.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_r <= W_ADDR;
      aw_word_r <= '0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
      if (aw_hs_s) begin
        aw_word_r <= s_axi_control_AWADDR[HOST_AXI_ADDR_BITS-1:2];
      end
    end
  end

  // Read-data multiplexer; CTRL shows the done flag as it stood before this read.
  always_comb begin
    arg_rd_s = 32'h0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      arg_rd_s = arg_rd_s |
                 ((ar_word_s == WORD_BITS'(ARG_BASE_WORD + i)) ? arg_r[i] : 32'h0);
    end
    if (ar_word_s == CTRL_WORD) begin
      rd_mux_s = {29'h0, ap_idle, done_r, ap_start_r};
    end else if (ar_word_s == RET_WORD) begin
      rd_mux_s = ret_r;
    end else begin
      rd_mux_s = arg_rd_s;
    end
  end

  // Read FSM next state; read data is captured at the AR handshake and held after.
  always_comb begin
    r_state_s = r_state_r;
    arready_s = 1'b0;
    rvalid_s  = 1'b0;
    rdata_s   = rdata_r;
    case (r_state_r)
      R_ADDR: begin
        if (s_axi_control_ARVALID) begin
          r_state_s = R_DATA;
          rdata_s   = rd_mux_s;
        end else begin
          r_state_s = R_ADDR;
          rdata_s   = rdata_r;
        end
      end
      R_DATA: begin
        if (s_axi_control_RREADY) begin
          r_state_s = R_ADDR;
        end else begin
          r_state_s = R_DATA;
        end
      end
      default: begin
        r_state_s = R_ADDR;
      end
    endcase
    case (r_state_s)
      R_ADDR:  arready_s = 1'b1;
      R_DATA:  rvalid_s  = 1'b1;
      default: arready_s = 1'b0;
    endcase
  end

  // Read FSM state and its registered channel outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_r <= R_ADDR;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0;
    end else begin
      r_state_r <= r_state_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
      rdata_r   <= rdata_s;
    end
  end

  // Kernel handshake bits: a start set beats a same-cycle ap_ready, a done pulse
  // beats a same-cycle CTRL read.
  always_ff @(posedge clock) begin
    if (reset) begin
      ap_start_r <= 1'b0;
      done_r     <= 1'b0;
      ret_r      <= 32'h0;
    end else begin
      if (start_set_s) begin
        ap_start_r <= 1'b1;
      end else if (ap_ready) begin
        ap_start_r <= 1'b0;
      end
      if (ap_done) begin
        done_r <= 1'b1;
      end else if (ctrl_rd_s) begin
        done_r <= 1'b0;
      end
      if (ap_done) begin
        ret_r <= ret_value;
      end
    end
  end

  // Argument registers, byte-strobed writes effective at the W handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      arg_r <= '0;
    end else begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (wr_en_s && (aw_word_r == WORD_BITS'(ARG_BASE_WORD + i))) begin
          arg_r[i] <= merge_bytes(arg_r[i], s_axi_control_WDATA, s_axi_control_WSTRB);
        end
      end
    end
  end

  assign s_axi_control_AWREADY = awready_r;
  assign s_axi_control_WREADY  = wready_r;
  assign s_axi_control_BVALID  = bvalid_r;
  assign s_axi_control_BRESP   = 2'b00;
  assign s_axi_control_ARREADY = arready_r;
  assign s_axi_control_RVALID  = rvalid_r;
  assign s_axi_control_RDATA   = rdata_r;
  assign s_axi_control_RRESP   = 2'b00;
  assign ap_start              = ap_start_r;
  assign args                  = arg_r;

endmodule

// File: tb/tb_axi_ctrl_slave.sv
// Self-checking bench for axi_ctrl_slave: a directed vector table, hand-written
// sequences for the handshake corner cases, then randomized traffic compared
// against a register-map model held in plain arrays.
module tb_axi_ctrl_slave;

  localparam int NARGS = 4;
  localparam int TMO   = 50;

  logic        clock;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [5:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        ap_start, ap_ready, ap_done, ap_idle;
  logic [31:0] ret_value;
  logic [32*NARGS-1:0] args;

  axi_ctrl_slave #(
    .HOST_AXI_ADDR_BITS(6),
    .HOST_AXI_DATA_BITS(32),
    .NUM_ARGS(NARGS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s_axi_control_AWVALID(awvalid),
    .s_axi_control_AWREADY(awready),
    .s_axi_control_AWADDR(awaddr),
    .s_axi_control_WVALID(wvalid),
    .s_axi_control_WREADY(wready),
    .s_axi_control_WDATA(wdata),
    .s_axi_control_WSTRB(wstrb),
    .s_axi_control_BVALID(bvalid),
    .s_axi_control_BREADY(bready),
    .s_axi_control_BRESP(bresp),
    .s_axi_control_ARVALID(arvalid),
    .s_axi_control_ARREADY(arready),
    .s_axi_control_ARADDR(araddr),
    .s_axi_control_RVALID(rvalid),
    .s_axi_control_RREADY(rready),
    .s_axi_control_RDATA(rdata),
    .s_axi_control_RRESP(rresp),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .ret_value(ret_value),
    .args(args)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the register map
  logic [31:0] m_arg [NARGS];
  logic [31:0] m_ret;
  logic        m_done;
  logic        m_start;

  logic ready_during_w = 1'b0;
  logic done_during_ar = 1'b0;
  logic start_after_w;

  typedef struct {
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NARGS; i++) m_arg[i] = 32'h0;
    m_ret = 32'h0;
    m_done = 1'b0;
    m_start = 1'b0;
  endtask

  task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int w;
    w = int'(addr[5:2]);
    if (w == 0) begin
      if (strb[0] && data[0]) m_start = 1'b1;
    end else if (w >= 4 && w < 4 + NARGS) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_arg[w-4][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic model_read(input logic [5:0] addr, output logic [31:0] exp);
    int w;
    w = int'(addr[5:2]);
    exp = 32'h0;
    if (w == 0) begin
      exp = {29'h0, ap_idle, m_done, m_start};
      m_done = 1'b0;
    end else if (w == 2) begin
      exp = m_ret;
    end else if (w >= 4 && w < 4 + NARGS) begin
      exp = m_arg[w-4];
    end
  endtask

  function automatic logic [127:0] model_args();
    return {m_arg[3], m_arg[2], m_arg[1], m_arg[0]};
  endfunction

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = addr;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < TMO) begin tick(); n++; end
    if (n >= TMO) check("aw_timeout", 128'd0, 128'd1);
    tick();
    awvalid = 1'b0;
    wdata = data;
    wstrb = strb;
    wvalid = 1'b1;
    n = 0;
    while (!wready && n < TMO) begin tick(); n++; end
    if (n >= TMO) check("w_timeout", 128'd0, 128'd1);
    if (ready_during_w) ap_ready = 1'b1;
    tick();
    wvalid = 1'b0;
    ap_ready = 1'b0;
    start_after_w = ap_start;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < TMO) begin tick(); n++; end
    if (n >= TMO) check("b_timeout", 128'd0, 128'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
    int n;
    araddr = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < TMO) begin tick(); n++; end
    if (n >= TMO) check("ar_timeout", 128'd0, 128'd1);
    if (done_during_ar) ap_done = 1'b1;
    tick();
    arvalid = 1'b0;
    ap_done = 1'b0;
    check("rvalid_latency", 128'(rvalid), 128'd1);
    check("rresp", 128'(rresp), 128'd0);
    data = rdata;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [31:0] exp;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;

    vecs[0]  = '{1'b1, 6'h10, 32'h12345678, 4'hF, 32'h0,        "w_arg0"};
    vecs[1]  = '{1'b0, 6'h10, 32'h0,        4'h0, 32'h12345678, "r_arg0"};
    vecs[2]  = '{1'b1, 6'h14, 32'hFFFFFFFF, 4'hF, 32'h0,        "w_arg1_ones"};
    vecs[3]  = '{1'b1, 6'h14, 32'h00000000, 4'h5, 32'h0,        "w_arg1_strb5"};
    vecs[4]  = '{1'b0, 6'h14, 32'h0,        4'h0, 32'hFF00FF00, "r_arg1"};
    vecs[5]  = '{1'b1, 6'h3C, 32'hDEADBEEF, 4'hF, 32'h0,        "w_unmapped"};
    vecs[6]  = '{1'b0, 6'h3C, 32'h0,        4'h0, 32'h0,        "r_unmapped"};
    vecs[7]  = '{1'b1, 6'h08, 32'hDEADBEEF, 4'hF, 32'h0,        "w_ret"};
    vecs[8]  = '{1'b0, 6'h08, 32'h0,        4'h0, 32'h0,        "r_ret"};
    vecs[9]  = '{1'b1, 6'h1B, 32'hA5A5A5A5, 4'h2, 32'h0,        "w_arg2_byte1"};
    vecs[10] = '{1'b0, 6'h1A, 32'h0,        4'h0, 32'h0000A500, "r_arg2"};
    vecs[11] = '{1'b1, 6'h00, 32'hFFFFFFFE, 4'hF, 32'h0,        "w_ctrl_ro_bits"};
    vecs[12] = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h0,        "r_ctrl"};
    vecs[13] = '{1'b0, 6'h04, 32'h0,        4'h0, 32'h0,        "r_word1"};
    vecs[14] = '{1'b0, 6'h20, 32'h0,        4'h0, 32'h0,        "r_past_args"};

    reset = 1'b1;
    awvalid = 1'b0; awaddr = 6'h0; wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    bready = 1'b0; arvalid = 1'b0; araddr = 6'h0; rready = 1'b0;
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b0; ret_value = 32'h0;
    model_reset();

    // Reset state
    tick(); tick(); tick();
    check("rst_awready", 128'(awready), 128'd0);
    check("rst_wready",  128'(wready),  128'd0);
    check("rst_bvalid",  128'(bvalid),  128'd0);
    check("rst_arready", 128'(arready), 128'd0);
    check("rst_rvalid",  128'(rvalid),  128'd0);
    check("rst_rdata",   128'(rdata),   128'd0);
    check("rst_ap_start", 128'(ap_start), 128'd0);
    check("rst_args",    128'(args),    128'd0);
    check("rst_bresp",   128'(bresp),   128'd0);
    reset = 1'b0;
    tick();
    check("post_rst_awready", 128'(awready), 128'd1);
    check("post_rst_arready", 128'(arready), 128'd1);

    // Directed vector table
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].is_write) begin
        axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp);
        check({vecs[v].name, "_bresp"}, 128'(resp), 128'd0);
        model_write(vecs[v].addr, vecs[v].data, vecs[v].strb);
      end else begin
        axi_read(vecs[v].addr, rd);
        check(vecs[v].name, 128'(rd), 128'(vecs[v].exp));
        model_read(vecs[v].addr, exp);
      end
    end
    check("tbl_args", 128'(args), {32'h0, 32'h0000A500, 32'hFF00FF00, 32'h12345678});
    check("tbl_ap_start", 128'(ap_start), 128'd0);

    // Start: set, hold, clear one cycle after ap_ready
    axi_write(6'h00, 32'h1, 4'h1, resp);
    check("start_next_cycle", 128'(start_after_w), 128'd1);
    tick(); tick();
    check("start_held", 128'(ap_start), 128'd1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    check("start_cleared", 128'(ap_start), 128'd0);

    // Start set collides with ap_ready: set wins; writing 0 does not clear
    ready_during_w = 1'b1;
    axi_write(6'h00, 32'h1, 4'hF, resp);
    ready_during_w = 1'b0;
    check("start_set_wins", 128'(start_after_w), 128'd1);
    axi_write(6'h00, 32'h0, 4'hF, resp);
    check("start_write0_noop", 128'(ap_start), 128'd1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    check("start_cleared2", 128'(ap_start), 128'd0);
    m_start = 1'b0;

    // Done flag, idle, return value
    ap_idle = 1'b1;
    ret_value = 32'hCAFEF00D;
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    ret_value = 32'h11111111;
    axi_read(6'h00, rd);
    check("ctrl_done_idle", 128'(rd), 128'h6);
    axi_read(6'h08, rd);
    check("ret_latched", 128'(rd), 128'hCAFEF00D);
    axi_read(6'h00, rd);
    check("ctrl_done_cleared", 128'(rd), 128'h4);

    // ap_done in the same cycle as a CTRL read handshake: done survives
    done_during_ar = 1'b1;
    axi_read(6'h00, rd);
    done_during_ar = 1'b0;
    axi_read(6'h00, rd);
    check("done_survives_rd", 128'(rd), 128'h6);
    axi_read(6'h00, rd);
    check("done_clear_after", 128'(rd), 128'h4);
    axi_read(6'h08, rd);
    check("ret_second", 128'(rd), 128'h11111111);
    m_ret = 32'h11111111;
    m_done = 1'b0;

    // Read stall: RDATA/RVALID held, ARREADY low until the R handshake
    araddr = 6'h10;
    arvalid = 1'b1;
    for (int n = 0; n < TMO && !arready; n++) tick();
    tick();
    araddr = 6'h14;
    for (int c = 0; c < 5; c++) begin
      check("stall_rvalid", 128'(rvalid), 128'd1);
      check("stall_rdata", 128'(rdata), 128'h12345678);
      check("stall_arready", 128'(arready), 128'd0);
      tick();
    end
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("stall_rvalid_drop", 128'(rvalid), 128'd0);
    check("stall_arready_back", 128'(arready), 128'd1);

    // Randomized traffic against the model
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          addr = 6'($urandom_range(0, 63));
          data = $urandom;
          strb = 4'($urandom_range(0, 15));
          axi_write(addr, data, strb, resp);
          model_write(addr, data, strb);
          check("rnd_bresp", 128'(resp), 128'd0);
          check("rnd_args", 128'(args), model_args());
        end
        2: begin
          addr = 6'($urandom_range(0, 63));
          axi_read(addr, rd);
          model_read(addr, exp);
          check("rnd_rdata", 128'(rd), 128'(exp));
        end
        default: begin
          ap_idle = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) begin
            ap_done = 1'b1;
            ret_value = $urandom;
            m_done = 1'b1;
            m_ret = ret_value;
          end
          if ($urandom_range(0, 1) == 1) begin
            ap_ready = 1'b1;
            m_start = 1'b0;
          end
          tick();
          ap_done = 1'b0;
          ap_ready = 1'b0;
          check("rnd_ap_start", 128'(ap_start), 128'(m_start));
        end
      endcase
    end

    // Reset while waiting in the data phase
    awaddr = 6'h10;
    awvalid = 1'b1;
    for (int n = 0; n < TMO && !awready; n++) tick();
    tick();
    awvalid = 1'b0;
    check("wdata_phase_wready", 128'(wready), 128'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_wready", 128'(wready), 128'd0);
    check("mid_rst_bvalid", 128'(bvalid), 128'd0);
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    check("mid_rst_awready", 128'(awready), 128'd1);
    check("mid_rst_args", 128'(args), 128'd0);
    for (int c = 0; c < 3; c++) begin
      check("mid_rst_no_bvalid", 128'(bvalid), 128'd0);
      tick();
    end
    axi_read(6'h08, rd);
    check("mid_rst_ret", 128'(rd), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
